// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for up to 8 requesters with ownership hold
// and a watchdog that reclaims the bus from a stalled owner.
module bus_arbiter #(
  parameter int unsigned INPUTS        = 4,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned TIMEOUT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INPUTS-1:0] request,
  input  logic              transferDone,
  output logic [INPUTS-1:0] grant,
  output logic              grantValid,
  output logic [2:0]        grantIndex,
  output logic              timeoutError,
  output logic [2:0]        timeoutIndex
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned MAX_IN = 8;
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(INPUTS - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] EXPIRY = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam bit WDOG_EN = (TIMEOUT != 0);

  // Elaboration-time parameter legality checks
  if (INPUTS < 1 || INPUTS > MAX_IN) begin : g_bad_inputs
    $error("bus_arbiter: INPUTS must be in 1..8");
  end
  if (TIMEOUT_WIDTH < 1 || TIMEOUT_WIDTH > 32 ||
      64'(TIMEOUT) >= (64'd1 << TIMEOUT_WIDTH)) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT does not fit in TIMEOUT_WIDTH");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [INPUTS-1:0]        grant_q, grant_d;
  logic                     grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]         grant_index_q, grant_index_d;
  logic                     timeout_error_q, timeout_error_d;
  logic [IDX_W-1:0]         timeout_index_q, timeout_index_d;
  logic [TIMEOUT_WIDTH-1:0] counter_q, counter_d;
  logic [INPUTS-1:0]        mask_q, mask_d;
  logic [IDX_W-1:0]         last_index_q, last_index_d;

  logic [MAX_IN-1:0]        eligible;
  logic [MAX_IN-1:0]        req_wide;
  logic [IDX_W:0]           arb_sum;
  logic                     win_found;
  logic [IDX_W-1:0]         win_idx;
  logic                     owner_req;
  logic                     expired;

  // Round-robin search: first eligible requester after the last winner
  always_comb begin
    eligible  = MAX_IN'(request & ~mask_q);
    arb_sum   = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 1; off <= INPUTS; off++) begin
      arb_sum = (IDX_W + 1)'(last_index_q) + (IDX_W + 1)'(off);
      if (arb_sum >= (IDX_W + 1)'(INPUTS)) begin
        arb_sum = arb_sum - (IDX_W + 1)'(INPUTS);
      end
      if (!win_found && eligible[arb_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = arb_sum[IDX_W-1:0];
      end
    end
  end

  // Owner request level and watchdog expiry for the current grant
  always_comb begin
    req_wide  = MAX_IN'(request);
    owner_req = req_wide[grant_index_q];
    expired   = WDOG_EN && !transferDone && (counter_q == EXPIRY);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    grant_valid_d   = grant_valid_q;
    grant_index_d   = grant_index_q;
    timeout_error_d = 1'b0;
    timeout_index_d = timeout_index_q;
    counter_d       = counter_q;
    last_index_d    = last_index_q;
    // a mask bit is forgotten as soon as its requester lets go
    mask_d          = mask_q & request;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d       = GRANT;
          grant_d       = INPUTS'(1) << win_idx;
          grant_valid_d = 1'b1;
          grant_index_d = win_idx;
          last_index_d  = win_idx;
          counter_d     = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // normal release wins over a simultaneous watchdog expiry
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_index_d = '0;
          counter_d     = '0;
        end else if (expired) begin
          state_d         = IDLE;
          grant_d         = '0;
          grant_valid_d   = 1'b0;
          grant_index_d   = '0;
          counter_d       = '0;
          timeout_error_d = 1'b1;
          timeout_index_d = grant_index_q;
          mask_d          = mask_d | grant_q;
        end else if (transferDone) begin
          counter_d = '0;
        end else begin
          counter_d = counter_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      grant_valid_q   <= 1'b0;
      grant_index_q   <= '0;
      timeout_error_q <= 1'b0;
      timeout_index_q <= '0;
      counter_q       <= '0;
      mask_q          <= '0;
      last_index_q    <= LAST_RESET;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      grant_valid_q   <= grant_valid_d;
      grant_index_q   <= grant_index_d;
      timeout_error_q <= timeout_error_d;
      timeout_index_q <= timeout_index_d;
      counter_q       <= counter_d;
      mask_q          <= mask_d;
      last_index_q    <= last_index_d;
    end
  end

  assign grant        = grant_q;
  assign grantValid   = grant_valid_q;
  assign grantIndex   = grant_index_q;
  assign timeoutError = timeout_error_q;
  assign timeoutIndex = timeout_index_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random stimulus against a behavioural model
// for a 4-requester and a 1-requester arbiter, both with TIMEOUT=4.
module tb_bus_arbiter;

  localparam int unsigned TB_TIMEOUT = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req4;
  logic       done4;
  logic [0:0] req1;
  logic       done1;

  logic [3:0] grant4;
  logic       gv4;
  logic [2:0] gidx4;
  logic       terr4;
  logic [2:0] tidx4;
  logic [0:0] grant1;
  logic       gv1;
  logic [2:0] gidx1;
  logic       terr1;
  logic [2:0] tidx1;

  int total = 0;
  int bad   = 0;

  // model state per instance: 0 -> 4 inputs, 1 -> 1 input
  int         m_n     [2] = '{4, 1};
  int         m_owner [2] = '{-1, -1};
  int         m_last  [2] = '{3, 0};
  int         m_stall [2] = '{0, 0};
  logic [7:0] m_blk   [2] = '{8'd0, 8'd0};
  int         m_terr  [2] = '{0, 0};
  int         m_tidx  [2] = '{0, 0};

  bus_arbiter #(.INPUTS(4), .TIMEOUT(TB_TIMEOUT), .TIMEOUT_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .request(req4), .transferDone(done4),
    .grant(grant4), .grantValid(gv4), .grantIndex(gidx4),
    .timeoutError(terr4), .timeoutIndex(tidx4)
  );

  bus_arbiter #(.INPUTS(1), .TIMEOUT(TB_TIMEOUT), .TIMEOUT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .request(req1), .transferDone(done1),
    .grant(grant1), .grantValid(gv1), .grantIndex(gidx1),
    .timeoutError(terr1), .timeoutIndex(tidx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock of the arbitration rules, applied to the inputs seen at the edge
  task automatic model_step(input int u, input logic [7:0] req, input logic done, input logic r);
    int n;
    int c;
    n = m_n[u];
    if (r) begin
      m_owner[u] = -1;
      m_last[u]  = n - 1;
      m_stall[u] = 0;
      m_blk[u]   = 8'd0;
      m_terr[u]  = 0;
      m_tidx[u]  = 0;
      return;
    end
    m_terr[u] = 0;
    if (m_owner[u] < 0) begin
      for (int k = 1; k <= n; k++) begin
        c = (m_last[u] + k) % n;
        if (req[c] && !m_blk[u][c]) begin
          m_owner[u] = c;
          m_last[u]  = c;
          m_stall[u] = 0;
          break;
        end
      end
    end else if (!req[m_owner[u]]) begin
      m_owner[u] = -1;
    end else if (!done && (m_stall[u] + 1 == int'(TB_TIMEOUT))) begin
      m_blk[u][m_owner[u]] = 1'b1;
      m_tidx[u]  = m_owner[u];
      m_terr[u]  = 1;
      m_owner[u] = -1;
    end else begin
      m_stall[u] = done ? 0 : m_stall[u] + 1;
    end
    m_blk[u] = m_blk[u] & req;
  endtask

  function automatic logic [31:0] exp_grant(input int u);
    return (m_owner[u] >= 0) ? (32'd1 << m_owner[u]) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_idx(input int u);
    return (m_owner[u] >= 0) ? 32'(m_owner[u]) : 32'd0;
  endfunction

  task automatic compare_all();
    check("grant4",    32'(grant4), exp_grant(0));
    check("valid4",    32'(gv4),    32'(m_owner[0] >= 0));
    check("index4",    32'(gidx4),  exp_idx(0));
    check("terr4",     32'(terr4),  32'(m_terr[0]));
    check("tidx4",     32'(tidx4),  32'(m_tidx[0]));
    check("onehot4",   32'($onehot0(grant4)), 32'd1);
    check("valid_or4", 32'(gv4),    32'(|grant4));
    check("grant1",    32'(grant1), exp_grant(1));
    check("valid1",    32'(gv1),    32'(m_owner[1] >= 0));
    check("index1",    32'(gidx1),  32'd0);
    check("terr1",     32'(terr1),  32'(m_terr[1]));
    check("tidx1",     32'(tidx1),  32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 8'(req4), done4, rst);
    model_step(1, 8'(req1), done1, rst);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; req4 = 4'd0; done4 = 1'b0; req1 = 1'b0; done1 = 1'b0;
    tick(); tick();
    check("rst_grant4", 32'(grant4), 32'd0);
    rst = 1'b0;

    // first grant, turnaround, second grant; single-input drop and re-raise
    req4 = 4'b0110; req1 = 1'b1; done4 = 1'b1; done1 = 1'b1;
    tick();
    check("first_grant4", 32'(grant4), 32'h2);
    check("first_grant1", 32'(grant1), 32'h1);
    tick(); tick();
    req4 = 4'b0100; req1 = 1'b0;
    tick();
    check("turnaround4", 32'(grant4), 32'h0);
    check("drop1",       32'(grant1), 32'h0);
    req1 = 1'b1;
    tick();
    check("second_grant4", 32'(grant4), 32'h4);
    check("second_idx4",   32'(gidx4),  32'd2);
    check("regrant1",      32'(grant1), 32'h1);
    req4 = 4'd0;
    tick();

    // round-robin fairness from a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    req4 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick(); tick(); tick();
      check("rr_order", 32'(gidx4), 32'(i % 4));
      req4 = 4'hF & ~4'(exp_grant(0));
      tick();
      check("rr_gap", 32'(grant4), 32'h0);
      req4 = 4'hF;
    end
    req4 = 4'd0;
    tick();

    // watchdog expiry, masking and re-arm
    done4 = 1'b0;
    req4  = 4'b0100;
    repeat (4) tick();
    check("wd_held", 32'(grant4), 32'h4);
    tick();
    check("wd_pulse", 32'(terr4),  32'd1);
    check("wd_index", 32'(tidx4),  32'd2);
    check("wd_drop",  32'(grant4), 32'h0);
    req4 = 4'b1100;
    tick();
    check("wd_other", 32'(grant4), 32'h8);
    check("wd_once",  32'(terr4),  32'd0);
    done4 = 1'b1;
    tick();
    req4 = 4'b0100;
    tick();
    tick();
    check("wd_masked", 32'(grant4), 32'h0);
    req4 = 4'd0;
    tick();
    req4 = 4'b0100;
    tick();
    check("wd_regrant", 32'(grant4), 32'h4);
    req4 = 4'd0;
    tick();

    // periodic acks keep ownership; drop coinciding with expiry is a release
    req4 = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      done4 = (i % 3 == 2);
      tick();
    end
    check("ack_hold", 32'(grant4), 32'h1);
    done4 = 1'b1; tick();
    done4 = 1'b0; tick(); tick(); tick();
    req4 = 4'd0;
    tick();
    check("coincide_err",   32'(terr4),  32'd0);
    check("coincide_grant", 32'(grant4), 32'h0);

    // reset while requester 3 owns the bus
    done4 = 1'b1;
    req4 = 4'b1000;
    tick();
    check("pre_rst_grant", 32'(grant4), 32'h8);
    rst = 1'b1; req4 = 4'b1001;
    tick();
    check("mid_rst_grant", 32'(grant4), 32'h0);
    check("mid_rst_valid", 32'(gv4),    32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_grant", 32'(grant4), 32'h1);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 6 == 0) req4 = req4 ^ (4'd1 << ($urandom % 4));
      if ($urandom % 5 == 0) req1 = ~req1;
      done4 = ($urandom % 3 == 0);
      done1 = ($urandom % 3 == 0);
      rst   = ($urandom % 300 == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
